// File: rtl/tt_trng_conditioner.sv
// tt_trng_conditioner: synchronizes raw entropy, debiases/whitens it and packs it into words.
// Optional repetition-count health test is built when TT_TRNG_RCT_EN is defined.
module tt_trng_conditioner #(
  parameter int NUM_SRC = 4,
  parameter int WORD_W = 8,
  parameter int LFSR_W = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
  parameter int RCT_LIMIT = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] raw_in,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic               word_ready,
  input  logic               health_clr,
  output logic               word_valid,
  output logic [WORD_W-1:0]  word_data,
  output logic               overflow,
  output logic               health_fail
);
  localparam int CW = $clog2(WORD_W + 1);
  typedef enum logic {EMPTY, HAVE_FIRST} vn_t;
  logic [NUM_SRC-1:0] s1, s2;
  logic [LFSR_W-1:0] lfsr, lfsr_st, lfsr_n;
  logic [WORD_W-1:0] asm_q, asm_sh, asm_n, load_d;
  logic [CW-1:0] cnt, cnt_e, base, cnt_a, cnt_n;
  vn_t vn, vn_e, vn_n;
  logic vn_bit, vn_bit_n, vn_pair;
  logic [1:0] pmode;
  logic x, chg, bit_v, bit_d, full, can_load, acc, ld, ovf_set;
  always_comb begin
    x = ^s2;
    chg = mode != pmode;
    cnt_e = chg ? '0 : cnt;
    vn_e = chg ? EMPTY : vn;
    vn_pair = mode[1] ^ mode[0];
    vn_n = !enable ? EMPTY : !vn_pair ? vn_e : (vn_e == EMPTY) ? HAVE_FIRST : EMPTY;
    vn_bit_n = (enable && vn_pair && vn_e == EMPTY) ? x : vn_bit;
    bit_v = enable && (!vn_pair || (vn_e == HAVE_FIRST && x != vn_bit));
    bit_d = !vn_pair ? (mode[0] ? lfsr[0] : x) : vn_bit ^ (mode[1] & lfsr[0]);
    lfsr_st = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
    lfsr_n = (lfsr == '0) ? LFSR_W'(1) : enable ? lfsr_st : lfsr;
    // A full assembler drains into the holding register whenever it frees up
    full = cnt_e == CW'(WORD_W);
    can_load = (!word_valid || word_ready) && !health_fail;
    acc = bit_v && (!full || can_load);
    base = (full && can_load) ? '0 : cnt_e;
    cnt_a = base + CW'(acc);
    ld = can_load && (full || cnt_a == CW'(WORD_W));
    asm_sh = {bit_d, asm_q[WORD_W-1:1]};
    asm_n = acc ? asm_sh : asm_q;
    load_d = full ? asm_q : asm_sh;
    cnt_n = (ld && !full) ? '0 : cnt_a;
    ovf_set = bit_v && !acc;
  end
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      s1 <= '0;
      s2 <= '0;
      lfsr <= LFSR_W'(1);
      asm_q <= '0;
      cnt <= '0;
      vn <= EMPTY;
      vn_bit <= 1'b0;
      pmode <= 2'b00;
      word_data <= '0;
      word_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      s1 <= raw_in;
      s2 <= s1;
      lfsr <= lfsr_n;
      asm_q <= asm_n;
      cnt <= cnt_n;
      vn <= vn_n;
      vn_bit <= vn_bit_n;
      pmode <= mode;
      overflow <= overflow | ovf_set;
      if (ld) word_data <= load_d;
      word_valid <= ld | (word_valid & ~word_ready);
    end
  end
`ifdef TT_TRNG_RCT_EN
  logic [7:0] rc, rc_n;
  logic px;
  always_comb rc_n = (rc != 8'd0 && x == px) ? ((rc >= 8'(RCT_LIMIT)) ? rc : rc + 8'd1) : 8'd1;
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rc <= '0;
      px <= 1'b0;
      health_fail <= 1'b0;
    end else if (health_clr) begin
      rc <= '0;
      health_fail <= 1'b0;
    end else if (enable) begin
      rc <= rc_n;
      px <= x;
      if (rc_n >= 8'(RCT_LIMIT)) health_fail <= 1'b1;
    end
  end
`else
  logic rct_unused;
  assign rct_unused = health_clr;
  assign health_fail = 1'b0;
`endif
endmodule

// File: tb/tb_tt_trng_conditioner.sv
// tb_tt_trng_conditioner: scoreboard bench; a bit-level model queues expected words, handshakes pop them.
module tb_tt_trng_conditioner;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [3:0] raw_in = '0;
  logic enable = 1'b0;
  logic [1:0] mode = 2'b00;
  logic word_ready = 1'b0;
  logic health_clr = 1'b0;
  logic word_valid;
  logic [7:0] word_data;
  logic overflow;
  logic health_fail;
  int total = 0;
  int bad = 0;
  logic [7:0] q[$];
  logic [7:0] seen;
  logic [3:0] m_s1, m_s2;
  logic [15:0] m_lfsr;
  logic m_have, m_first, m_ovf;
  logic [7:0] m_acc;
  int m_pc;
  logic [1:0] m_pm;

  tt_trng_conditioner dut (
    .clk(clk), .rst_n(rst_n), .raw_in(raw_in), .enable(enable), .mode(mode),
    .word_ready(word_ready), .health_clr(health_clr), .word_valid(word_valid),
    .word_data(word_data), .overflow(overflow), .health_fail(health_fail)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic xb, b, bv;
    xb = ^m_s2;
    b = 1'b0;
    bv = 1'b0;
    if (mode != m_pm) begin
      m_pc = 0;
      m_have = 1'b0;
    end
    m_pm = mode;
    if (word_valid && word_ready) begin
      seen = word_data;
      if (q.size() == 0) check("unexpected_word", 32'(q.size()), 1);
      else check("word", word_data, q.pop_front());
    end
    if (enable) begin
      case (mode)
        2'b00: begin bv = 1'b1; b = xb; end
        2'b11: begin bv = 1'b1; b = m_lfsr[0]; end
        default: begin
          if (!m_have) begin
            m_have = 1'b1;
            m_first = xb;
          end else begin
            m_have = 1'b0;
            if (xb != m_first) begin
              bv = 1'b1;
              b = m_first ^ ((mode == 2'b10) & m_lfsr[0]);
            end
          end
        end
      endcase
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end else m_have = 1'b0;
    if (bv) begin
      if (q.size() >= 2) m_ovf = 1'b1;
      else begin
        m_acc[m_pc] = b;
        m_pc++;
        if (m_pc == 8) begin
          q.push_back(m_acc);
          m_pc = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    m_s2 = m_s1;
    m_s1 = raw_in;
  endtask

  task automatic rst_pulse();
    enable = 1'b0;
    raw_in = '0;
    rst_n = 1'b1;
    #2;
    check("rst_valid", word_valid, 0);
    check("rst_data", word_data, 0);
    check("rst_ovf", overflow, 0);
    check("rst_hf", health_fail, 0);
    m_s1 = '0; m_s2 = '0; m_lfsr = 16'h0001; m_have = 1'b0; m_first = 1'b0;
    m_acc = '0; m_pc = 0; m_ovf = 1'b0;
    q.delete();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    m_pm = mode;
  endtask

  task automatic alt_run(input int n, input int pre);
    for (int i = 0; i < n + pre; i++) begin
      raw_in = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      enable = i >= pre;
      tick();
    end
  endtask

  task automatic drain(input string tag);
    enable = 1'b0;
    word_ready = 1'b1;
    repeat (4) tick();
    check({"drain_", tag}, 32'(q.size()), 0);
  endtask

  initial begin
    mode = 2'b00;
    rst_pulse();
    word_ready = 1'b1;
    alt_run(32, 2);
    drain("raw");
    check("raw_55", seen, 8'h55);

    mode = 2'b01;
    rst_pulse();
    word_ready = 1'b1;
    alt_run(32, 2);
    drain("vn");
    check("vn_ff", seen, 8'hFF);

    mode = 2'b10;
    rst_pulse();
    word_ready = 1'b1;
    alt_run(48, 2);
    drain("vnlfsr");

    mode = 2'b11;
    rst_pulse();
    for (int i = 0; i < 60; i++) begin
      raw_in = 4'($urandom);
      enable = $urandom_range(0, 7) != 0;
      word_ready = 1'b1;
      tick();
    end
    drain("lfsr");
    mode = 2'b01;
    for (int i = 0; i < 120; i++) begin
      raw_in = 4'($urandom);
      enable = 1'b1;
      word_ready = $urandom_range(0, 3) == 0;
      tick();
    end
    check("rand_ovf", overflow, m_ovf);
    drain("rand");

    mode = 2'b00;
    rst_pulse();
    word_ready = 1'b0;
    alt_run(16, 2);
    check("bp_valid16", word_valid, 1);
    check("bp_ovf16", overflow, 0);
    alt_run(8, 2);
    check("bp_valid24", word_valid, 1);
    check("bp_data24", word_data, 8'h55);
    check("bp_ovf24", overflow, 1);
    check("bp_ovf_model", overflow, m_ovf);
    drain("bp");

    mode = 2'b11;
    rst_pulse();
    word_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      raw_in = 4'($urandom);
      enable = 1'b1;
      tick();
    end
    check("same_pre_valid", word_valid, 1);
    word_ready = 1'b1;
    tick();
    check("same_valid", word_valid, 1);
    check("same_ovf", overflow, 0);
    check("same_q", 32'(q.size()), 1);
    if (q.size() > 0) check("same_data", word_data, q[0]);
    drain("same");

    mode = 2'b00;
    rst_pulse();
    word_ready = 1'b1;
    alt_run(5, 2);
    rst_pulse();
    word_ready = 1'b1;
    alt_run(8, 2);
    drain("midrst");
    check("midrst_55", seen, 8'h55);

    mode = 2'b01;
    rst_pulse();
    raw_in = 4'b0011;
    enable = 1'b1;
    word_ready = 1'b1;
    repeat (31) tick();
`ifdef TT_TRNG_RCT_EN
    check("rct_31", health_fail, 0);
    tick();
    check("rct_32", health_fail, 1);
    health_clr = 1'b1;
    tick();
    check("rct_clr", health_fail, 0);
    health_clr = 1'b0;
    tick();
    check("rct_after", health_fail, 0);
`else
    repeat (9) tick();
    check("rct_off", health_fail, 0);
`endif
    check("rct_novalid", word_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tt_trng_conditioner.md
TT_TRNG_CONDITIONER -- requirements
Module: tt_trng_conditioner

Interface
REQ-001 Parameter NUM_SRC, default 4: number of raw entropy source bits (ring-oscillator samples).
REQ-002 Parameter WORD_W, default 8: output word width, 2..32.
REQ-003 Parameter LFSR_W, default 16: whitening LFSR width.
REQ-004 Parameter LFSR_TAPS, default 16'hB400: Galois feedback mask.
REQ-005 Parameter RCT_LIMIT, default 32: repetition-count cutoff, 2..255.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-high (1 = reset) despite the name.
REQ-008 raw_in  input  NUM_SRC  asynchronous raw entropy bits.
REQ-009 enable  input  1  1 = accept entropy.
REQ-010 mode  input  2  00 raw XOR, 01 von Neumann, 10 von Neumann XOR LFSR, 11 LFSR only.
REQ-011 word_ready  input  1  consumer accepts word.
REQ-012 health_clr  input  1  clears health_fail.
REQ-013 word_valid  output  1  word_data holds an unconsumed word.
REQ-014 word_data  output  WORD_W  conditioned random word.
REQ-015 overflow  output  1  sticky: bits discarded due to backpressure.
REQ-016 health_fail  output  1  sticky repetition-count failure.

Function
REQ-017 raw_in SHALL pass a 2-flop synchronizer; x = XOR-reduce of synchronized bits; raw_in change at edge n affects x used at edge n+2.
REQ-018 LFSR SHALL advance one Galois step every cycle enable=1; if state ever all-zero it SHALL load 1.
REQ-019 Mode 00/11: one bit per enabled cycle (x, or lfsr[0] respectively).
REQ-020 Mode 01/10: VN FSM states EMPTY, HAVE_FIRST; EMPTY->HAVE_FIRST storing x; HAVE_FIRST->EMPTY, emitting stored bit only if x differs (mode 10: XOR lfsr[0]); equal pair discarded.
REQ-021 Emitted bits SHALL shift into the assembler LSB first; after WORD_W bits the word moves to the holding register and word_valid rises the next cycle.
REQ-022 Transfer occurs when word_valid and word_ready are both 1; word_valid then falls unless a new word completes in the same cycle, in which case the new word loads and word_valid stays 1.
REQ-023 Assembler full and holding register full: further bits SHALL be discarded and overflow set; no existing word altered.
REQ-024 Change of mode between cycles SHALL clear assembler bit count and VN state; holding register retained.
REQ-025 enable=0: no bits accepted, VN state cleared to EMPTY, assembler contents kept, LFSR frozen.
REQ-026 Repetition counter SHALL count consecutive identical x (enable=1); reaching RCT_LIMIT sets health_fail.
REQ-027 While health_fail=1 no new words SHALL enter the holding register; a held word remains transferable.
REQ-028 health_clr=1 clears health_fail and repetition counter; simultaneous set and clear: clear wins.

Reset
REQ-029 rst_n=1 SHALL asynchronously clear word_valid, word_data, overflow, health_fail, synchronizer, assembler, counters; VN=EMPTY; LFSR=1.
REQ-030 Reset mid-word SHALL discard partial bits; first post-reset word contains only post-reset bits.

Configuration
REQ-031 Macro TT_TRNG_RCT_EN: defined -> repetition-count test per REQ-026..028; undefined -> no counter logic, health_fail tied 0, health_clr ignored.

Verification
REQ-032 NUM_SRC=4, mode 00, raw_in alternating 4'b0001/4'b0000 each cycle, first x=1, ready=1 -> word_data 8'h55 per 8 bits.
REQ-033 Same stimulus, mode 01 -> every pair (1,0) emits 1; word_data 8'hFF after 16 accepted x.
REQ-034 Mode 01, raw_in held 4'b0011 -> no word_valid; with TT_TRNG_RCT_EN, health_fail=1 after 32 identical x; health_clr drops it next cycle.
REQ-035 Mode 00, word_ready=0 for 24 bits -> first word held unchanged, word_valid=1, overflow=1 after assembler fills.
REQ-036 Completion and handshake same cycle -> word_valid stays 1, word_data updates to new word, no overflow.
REQ-037 rst_n pulse after 5 bits -> all outputs 0, next word equals 8 post-reset bits.
